// File: rtl/monitor_onchip_memory_dp.sv
// True dual-port monitor RAM: two Avalon-MM slaves on one clock, byte-enabled writes,
// pipelined reads with readdatavalid, global clken/reset_req stall, s1-priority write collisions.
module monitor_onchip_memory_dp #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 13,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "monitor_onchip_memory.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic                    s2_waitrequest,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    write_collision
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Contents at configuration come from INIT_FILE through the device memory-init flow.
  if ((READ_LATENCY != 1 && READ_LATENCY != 2) || (DATA_WIDTH % 8 != 0)) begin : g_bad_cfg
    $error("monitor_onchip_memory_dp: unsupported READ_LATENCY=%0d / DATA_WIDTH=%0d (INIT_FILE=%s)",
           READ_LATENCY, DATA_WIDTH, INIT_FILE);
  end

  logic en;
  logic s1_wr, s2_wr;
  logic [1:0] rd_acc;
  logic [1:0] rdv_w;
  logic [DATA_WIDTH-1:0] rd_word [2];
  logic [DATA_WIDTH-1:0] rdata_w [2];
  logic coll_d, write_collision_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign en             = clken & ~reset_req;
  assign s1_waitrequest = ~en;
  assign s2_waitrequest = ~en;

  // A read raised together with a write is dropped: the write wins.
  assign s1_wr     = en & s1_chipselect & s1_write;
  assign s2_wr     = en & s2_chipselect & s2_write;
  assign rd_acc[0] = en & s1_chipselect & s1_read & ~s1_write;
  assign rd_acc[1] = en & s2_chipselect & s2_read & ~s2_write;

  assign coll_d = s1_wr & s2_wr & (|s1_byteenable) & (|s2_byteenable) &
                  (s1_address == s2_address);

  // s2 lanes are scheduled first so that s1 overrides them on a same-address collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (s2_wr && s2_byteenable[i]) mem[s2_address][i*8 +: 8] <= s2_writedata[i*8 +: 8];
      if (s1_wr && s1_byteenable[i]) mem[s1_address][i*8 +: 8] <= s1_writedata[i*8 +: 8];
    end
  end

  // Sampled at the same edge as any write, so mixed-port read-during-write returns old data.
  assign rd_word[0] = mem[s1_address];
  assign rd_word[1] = mem[s2_address];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  rdv_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v1_q;
      logic [DATA_WIDTH-1:0] d1_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v1_q    <= 1'b0;
          d1_q    <= '0;
          rdv_q   <= 1'b0;
          rdata_q <= '0;
        end else if (en) begin
          v1_q  <= rd_acc[p];
          if (rd_acc[p]) d1_q <= rd_word[p];
          rdv_q <= v1_q;
          if (v1_q) rdata_q <= d1_q;
        end else begin
          // Inner stage holds across the stall; the strobe lasts exactly one cycle.
          rdv_q <= 1'b0;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdv_q   <= 1'b0;
          rdata_q <= '0;
        end else begin
          rdv_q <= rd_acc[p];
          if (rd_acc[p]) rdata_q <= rd_word[p];
        end
      end
    end

    assign rdv_w[p]   = rdv_q;
    assign rdata_w[p] = rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) write_collision_q <= 1'b0;
    else       write_collision_q <= coll_d;
  end

  assign s1_readdatavalid = rdv_w[0];
  assign s2_readdatavalid = rdv_w[1];
  assign s1_readdata      = rdata_w[0];
  assign s2_readdata      = rdata_w[1];
  assign write_collision  = write_collision_q;

endmodule

// File: tb/tb_monitor_onchip_memory_dp.sv
// Bench for monitor_onchip_memory_dp: READ_LATENCY=1 and =2 instances share one stimulus
// stream; a negedge monitor pops per-stream expectation queues and checks data and latency.
module tb_monitor_onchip_memory_dp;

  typedef struct {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ex;
  } req_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clken = 1'b1;
  logic reset_req = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] s1_address = '0, s2_address = '0;
  logic        s1_chipselect = 1'b0, s2_chipselect = 1'b0;
  logic        s1_read = 1'b0, s2_read = 1'b0;
  logic        s1_write = 1'b0, s2_write = 1'b0;
  logic [3:0]  s1_byteenable = '0, s2_byteenable = '0;
  logic [31:0] s1_writedata = '0, s2_writedata = '0;

  // Streams: 0 = LAT1 s1, 1 = LAT1 s2, 2 = LAT2 s1, 3 = LAT2 s2
  logic        rdv  [4];
  logic [31:0] rdat [4];
  logic        wreq [4];
  logic        coll [2];

  monitor_onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .READ_LATENCY(1), .INIT_FILE("")) u_lat1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_waitrequest(wreq[0]),
    .s1_readdata(rdat[0]), .s1_readdatavalid(rdv[0]),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_waitrequest(wreq[1]),
    .s2_readdata(rdat[1]), .s2_readdatavalid(rdv[1]),
    .write_collision(coll[0])
  );

  monitor_onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .READ_LATENCY(2), .INIT_FILE("")) u_lat2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_waitrequest(wreq[2]),
    .s1_readdata(rdat[2]), .s1_readdatavalid(rdv[2]),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_waitrequest(wreq[3]),
    .s2_readdata(rdat[3]), .s2_readdatavalid(rdv[3]),
    .write_collision(coll[1])
  );

  // ---------------- scoreboard state ----------------
  exp_t exp_q [4][$];
  int   col_q [2][$];
  int   en_edges = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) begin
    if (!reset && clken && !reset_req) en_edges <= en_edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  function automatic req_t nop();
    nop = '{cs: 1'b0, rd: 1'b0, wr: 1'b0, addr: 13'd0, be: 4'd0, wdata: 32'd0, ex: 32'd0};
  endfunction

  function automatic req_t rd_req(input logic [12:0] a, input logic [31:0] e);
    rd_req = '{cs: 1'b1, rd: 1'b1, wr: 1'b0, addr: a, be: 4'd0, wdata: 32'd0, ex: e};
  endfunction

  function automatic req_t wr_req(input logic [12:0] a, input logic [3:0] b, input logic [31:0] d);
    wr_req = '{cs: 1'b1, rd: 1'b0, wr: 1'b1, addr: a, be: b, wdata: d, ex: 32'd0};
  endfunction

  // Drives one cycle; expectations are queued only when the request will be accepted.
  task automatic drive(input logic ck, input logic rq, input req_t p1, input req_t p2, input logic col_exp);
    clken = ck; reset_req = rq;
    s1_chipselect = p1.cs; s1_read = p1.rd; s1_write = p1.wr; s1_address = p1.addr;
    s1_byteenable = p1.be; s1_writedata = p1.wdata;
    s2_chipselect = p2.cs; s2_read = p2.rd; s2_write = p2.wr; s2_address = p2.addr;
    s2_byteenable = p2.be; s2_writedata = p2.wdata;
    if (ck && !rq) begin
      if (p1.cs && p1.rd && !p1.wr) begin
        exp_q[0].push_back('{data: p1.ex, due: en_edges + 1});
        exp_q[2].push_back('{data: p1.ex, due: en_edges + 2});
      end
      if (p2.cs && p2.rd && !p2.wr) begin
        exp_q[1].push_back('{data: p2.ex, due: en_edges + 1});
        exp_q[3].push_back('{data: p2.ex, due: en_edges + 2});
      end
      if (col_exp) begin
        col_q[0].push_back(en_edges + 1);
        col_q[1].push_back(en_edges + 1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, nop(), nop(), 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("%s_rdv%0d", tag, s), {31'd0, rdv[s]}, 32'd0);
      check($sformatf("%s_rdata%0d", tag, s), rdat[s], 32'd0);
    end
    for (int d = 0; d < 2; d++) check($sformatf("%s_coll%0d", tag, d), {31'd0, coll[d]}, 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    int   due;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("waitrequest%0d", s), {31'd0, wreq[s]}, {31'd0, ~(clken & ~reset_req)});
      if (!reset) begin
        if (rdv[s]) begin
          if (exp_q[s].size() == 0) begin
            check($sformatf("unexpected_rdv%0d", s), {31'd0, rdv[s]}, 32'd0);
          end else begin
            e = exp_q[s].pop_front();
            check($sformatf("rdata%0d", s), rdat[s], e.data);
            check($sformatf("latency%0d", s), en_edges, e.due);
          end
        end else if (exp_q[s].size() != 0 && exp_q[s][0].due < en_edges) begin
          e = exp_q[s].pop_front();
          check($sformatf("missing_rdv%0d", s), {31'd0, rdv[s]}, 32'd1);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        if (coll[d]) begin
          if (col_q[d].size() == 0) begin
            check($sformatf("unexpected_coll%0d", d), {31'd0, coll[d]}, 32'd0);
          end else begin
            due = col_q[d].pop_front();
            check($sformatf("coll_time%0d", d), en_edges, due);
          end
        end else if (col_q[d].size() != 0 && col_q[d][0] < en_edges) begin
          due = col_q[d].pop_front();
          check($sformatf("missing_coll%0d", d), {31'd0, coll[d]}, 32'd1);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_init");
    reset = 1'b0;

    // write then read, both ports, both latency instances
    drive(1, 0, wr_req(13'h010, 4'hF, 32'hDEADBEEF), nop(), 0);
    drive(1, 0, rd_req(13'h010, 32'hDEADBEEF), nop(), 0);
    drive(1, 0, nop(), wr_req(13'h020, 4'hF, 32'hCAFEF00D), 0);
    drive(1, 0, nop(), rd_req(13'h020, 32'hCAFEF00D), 0);
    drive(1, 0, rd_req(13'h020, 32'hCAFEF00D), rd_req(13'h010, 32'hDEADBEEF), 0);

    // byte enables
    drive(1, 0, wr_req(13'd5, 4'hF, 32'h11223344), nop(), 0);
    drive(1, 0, wr_req(13'd5, 4'b0101, 32'hAABBCCDD), nop(), 0);
    drive(1, 0, nop(), rd_req(13'd5, 32'h11BB33DD), 0);

    // mixed-port read-during-write returns old data, both directions
    drive(1, 0, wr_req(13'd7, 4'hF, 32'h0), nop(), 0);
    drive(1, 0, wr_req(13'd7, 4'hF, 32'h55), rd_req(13'd7, 32'h0), 0);
    drive(1, 0, nop(), rd_req(13'd7, 32'h55), 0);
    drive(1, 0, rd_req(13'd7, 32'h55), wr_req(13'd7, 4'hF, 32'h66), 0);
    drive(1, 0, rd_req(13'd7, 32'h66), nop(), 0);

    // write-write collisions: overlapping and disjoint lanes
    drive(1, 0, wr_req(13'd9, 4'b0011, 32'h0000AAAA), wr_req(13'd9, 4'hF, 32'hBBBBBBBB), 1);
    drive(1, 0, rd_req(13'd9, 32'hBBBBAAAA), nop(), 0);
    drive(1, 0, wr_req(13'hA, 4'b0011, 32'h00001111), wr_req(13'hA, 4'b1100, 32'h22220000), 1);
    drive(1, 0, nop(), rd_req(13'hA, 32'h22221111), 0);
    idle(1);

    // stall: four back-to-back reads, clken low for three cycles mid-stream
    drive(1, 0, wr_req(13'h100, 4'hF, 32'h10000000), wr_req(13'h101, 4'hF, 32'h10000001), 0);
    drive(1, 0, wr_req(13'h102, 4'hF, 32'h10000002), wr_req(13'h103, 4'hF, 32'h10000003), 0);
    drive(1, 0, rd_req(13'h100, 32'h10000000), nop(), 0);
    drive(1, 0, rd_req(13'h101, 32'h10000001), nop(), 0);
    repeat (3) drive(0, 0, rd_req(13'h102, 32'h10000002), nop(), 0);
    drive(1, 0, rd_req(13'h102, 32'h10000002), nop(), 0);
    drive(1, 0, rd_req(13'h103, 32'h10000003), nop(), 0);

    // read+write together: write wins, no strobe; reset_req stalls like clken=0
    drive(1, 0, '{cs: 1'b1, rd: 1'b1, wr: 1'b1, addr: 13'd3, be: 4'hF, wdata: 32'h77, ex: 32'h0},
          nop(), 0);
    drive(1, 1, rd_req(13'd3, 32'h77), nop(), 0);
    drive(1, 0, rd_req(13'd3, 32'h77), nop(), 0);
    idle(4);

    // reset one cycle after a read is accepted: that read must never strobe
    drive(1, 0, rd_req(13'd5, 32'h11BB33DD), nop(), 0);
    for (int s = 0; s < 4; s++) void'(exp_q[s].pop_back());
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    reset = 1'b0;
    idle(3);
    drive(1, 0, rd_req(13'd5, 32'h11BB33DD), nop(), 0);
    idle(5);

    for (int s = 0; s < 4; s++) check($sformatf("leftover_rd%0d", s), exp_q[s].size(), 32'd0);
    for (int d = 0; d < 2; d++) check($sformatf("leftover_coll%0d", d), col_q[d].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
